zap_mem_arbiter: RTL and testbench

Merges the core's two memory ports (instruction read port and data read/write port) onto one single-ported, ack-handshaked memory bus. It sits directly downstream of `zap_top` and upstream of a single-port RAM or external bus. It generates the stall signals the core obeys. Data writes are posted into a small write buffer so that stores normally complete without stalling.

---
 rtl/zap_mem_arb_pkg.sv | 29 ++
 rtl/zap_wbuf_fifo.sv | 77 +++++++
 rtl/zap_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_zap_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_mem_arb_pkg.sv
// Shared types for the zap memory arbiter: FSM states, grant encoding and
// the write-buffer entry layout.
package zap_mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    DREAD  = 2'd2,
    IREAD  = 2'd3
  } arb_state_t;

  // Which read port received the most recent grant.
  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } grant_t;

  // One posted data write: 32 + 32 + 4 = 68 bits.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
  } wbuf_entry_t;

  localparam int          WBUF_ENTRY_W = $bits(wbuf_entry_t);
  localparam logic [3:0]  BEN_ALL      = 4'hF;

endpackage

// File: rtl/zap_wbuf_fifo.sv
// Small write-buffer FIFO. Exposes the head entry and the one behind it so
// the arbiter can chain drains without an idle cycle. A push on a full
// buffer is accepted when a pop happens in the same cycle.
module zap_wbuf_fifo
  import zap_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wbuf_entry_t              push_data,
  output wbuf_entry_t              head,
  output wbuf_entry_t              head_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx_next;
  logic          push_ok;
  logic          pop_ok;
  wbuf_entry_t   entry_q [DEPTH];

  assign wr_idx      = wr_ptr_reg[AW-1:0];
  assign rd_idx      = rd_ptr_reg[AW-1:0];
  assign rd_idx_next = rd_idx + AW'(1);
  assign count       = wr_ptr_reg - rd_ptr_reg;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (count == '0);
  // When full, the slot being written is the one being popped this cycle.
  assign push_ok     = push && (!full || pop);
  assign pop_ok      = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      wbuf_entry_t entry_reg;

      // Load this slot when the write pointer addresses it.
      always_ff @(posedge clk) begin
        if (push_ok && (wr_idx == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign head      = entry_q[rd_idx];
  assign head_next = entry_q[rd_idx_next];

  // Advance the read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: merges the core's instruction and data ports onto one
// ack-handshaked memory bus. Data writes are posted into a write buffer;
// reads are only granted once that buffer has fully drained.
module zap_mem_arbiter
  import zap_mem_arb_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dram_rd_en,
  input  logic        i_dram_wr_en,
  input  logic [31:0] i_dram_addr,
  input  logic [31:0] i_dram_data,
  input  logic [3:0]  i_dram_ben,
  output logic [31:0] o_dram_data,
  output logic        o_dram_stall,
  input  logic        i_iram_rd_en,
  input  logic [31:0] i_iram_addr,
  output logic [31:0] o_iram_data,
  output logic        o_iram_stall,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_ben,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  arb_state_t  state_reg, state_next;
  grant_t      last_grant_reg, last_grant_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_wen_reg, mem_wen_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_ben_reg, mem_ben_next;
  logic [31:0] dram_hold_reg;
  logic [31:0] iram_hold_reg;

  wbuf_entry_t      wb_head, wb_head_next, wb_push_data, wb_sel;
  logic             wb_push, wb_pop, wb_full, wb_empty, wb_left;
  logic [CNT_W-1:0] wb_count;

  logic dram_ack, iram_ack, arb_eval;
  logic d_pend, i_pend, grant_d;

  zap_wbuf_fifo #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk      (i_clk),
    .rst      (i_reset),
    .push     (wb_push),
    .pop      (wb_pop),
    .push_data(wb_push_data),
    .head     (wb_head),
    .head_next(wb_head_next),
    .count    (wb_count),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  // Address bits [1:0] are forwarded untouched; the memory decodes words.
  assign wb_push_data = '{addr: i_dram_addr, data: i_dram_data, ben: i_dram_ben};
  assign wb_pop       = (state_reg == WDRAIN) && i_mem_ack;
  // A write always wins over a simultaneous (illegal) read request.
  assign wb_push      = i_dram_wr_en && (!wb_full || wb_pop);

  assign dram_ack = (state_reg == DREAD) && i_mem_ack;
  assign iram_ack = (state_reg == IREAD) && i_mem_ack;
  assign arb_eval = (state_reg == IDLE) || i_mem_ack;

  // The port completing on this ack is not a new request.
  assign d_pend  = i_dram_rd_en && !i_dram_wr_en && (state_reg != DREAD);
  assign i_pend  = i_iram_rd_en && (state_reg != IREAD);
  assign grant_d = d_pend && (!i_pend || (last_grant_reg == GRANT_I));

  // Entries still waiting after this cycle's pop; pushes this cycle are not
  // visible yet, so a buffered write reaches memory a cycle after its push.
  assign wb_left = wb_pop ? (wb_count > CNT_W'(1)) : !wb_empty;
  assign wb_sel  = wb_pop ? wb_head_next : wb_head;

  assign o_dram_stall = (i_dram_wr_en && wb_full && !wb_pop) ||
                        (i_dram_rd_en && !i_dram_wr_en && !dram_ack);
  assign o_iram_stall = i_iram_rd_en && !iram_ack;

  assign o_dram_data = dram_ack ? i_mem_rdata : dram_hold_reg;
  assign o_iram_data = iram_ack ? i_mem_rdata : iram_hold_reg;

  assign o_mem_req   = mem_req_reg;
  assign o_mem_wen   = mem_wen_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_ben   = mem_ben_reg;

  // Next grant and bus payload, decided in IDLE or on an ack cycle.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_wen_next    = mem_wen_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_ben_next    = mem_ben_reg;
    if (arb_eval) begin
      if (wb_left) begin
        state_next     = WDRAIN;
        mem_req_next   = 1'b1;
        mem_wen_next   = 1'b1;
        mem_addr_next  = wb_sel.addr;
        mem_wdata_next = wb_sel.data;
        mem_ben_next   = wb_sel.ben;
      end else if (wb_push) begin
        // A store is entering the buffer now; hold reads back behind it.
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_wen_next = 1'b0;
      end else if (grant_d) begin
        state_next      = DREAD;
        last_grant_next = GRANT_D;
        mem_req_next    = 1'b1;
        mem_wen_next    = 1'b0;
        mem_addr_next   = i_dram_addr;
        mem_ben_next    = BEN_ALL;
      end else if (i_pend) begin
        state_next      = IREAD;
        last_grant_next = GRANT_I;
        mem_req_next    = 1'b1;
        mem_wen_next    = 1'b0;
        mem_addr_next   = i_iram_addr;
        mem_ben_next    = BEN_ALL;
      end else begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_wen_next = 1'b0;
      end
    end
  end

  // State, round-robin pointer and registered bus payload.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      mem_req_reg    <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_ben_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_wen_reg    <= mem_wen_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_ben_reg    <= mem_ben_next;
    end
  end

  // Capture read data so each port keeps presenting its last result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dram_hold_reg <= '0;
      iram_hold_reg <= '0;
    end else begin
      if (dram_ack) begin
        dram_hold_reg <= i_mem_rdata;
      end
      if (iram_ack) begin
        iram_hold_reg <= i_mem_rdata;
      end
    end
  end

  // Simultaneous data read and write is illegal; the write wins in hardware.
  a_no_dram_rd_wr: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_dram_rd_en && i_dram_wr_en));

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// Directed testbench for zap_mem_arbiter with a simple acking memory model.
module tb_zap_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_dram_rd_en = 1'b0;
  logic        i_dram_wr_en = 1'b0;
  logic [31:0] i_dram_addr = '0;
  logic [31:0] i_dram_data = '0;
  logic [3:0]  i_dram_ben = '0;
  logic [31:0] o_dram_data;
  logic        o_dram_stall;
  logic        i_iram_rd_en = 1'b0;
  logic [31:0] i_iram_addr = '0;
  logic [31:0] o_iram_data;
  logic        o_iram_stall;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_ben;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;

  int total = 0;
  int bad = 0;

  // Memory model state.
  logic [31:0] mem_arr [0:255];
  int          wait_cnt;
  logic        ack_en = 1'b0;
  int          ack_delay = 0;
  logic [31:0] log_addr [$];
  logic        log_wen [$];
  logic [31:0] log_data [$];

  zap_mem_arbiter #(.WBUF_DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_dram_rd_en(i_dram_rd_en),
    .i_dram_wr_en(i_dram_wr_en),
    .i_dram_addr (i_dram_addr),
    .i_dram_data (i_dram_data),
    .i_dram_ben  (i_dram_ben),
    .o_dram_data (o_dram_data),
    .o_dram_stall(o_dram_stall),
    .i_iram_rd_en(i_iram_rd_en),
    .i_iram_addr (i_iram_addr),
    .o_iram_data (o_iram_data),
    .o_iram_stall(o_iram_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_wen   (o_mem_wen),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_ben   (o_mem_ben),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack)
  );

  always #5 i_clk = ~i_clk;

  // Ack arrives after ack_delay waiting cycles of a request.
  assign i_mem_ack   = o_mem_req && ack_en && (wait_cnt >= ack_delay);
  assign i_mem_rdata = i_mem_ack ? mem_arr[o_mem_addr[9:2]] : 32'h0;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= 0;
      for (int k = 0; k < 256; k++) mem_arr[k] <= 32'h0;
      mem_arr[8'h40] <= 32'hDEADBEEF;   // 0x100
      mem_arr[8'h50] <= 32'h55AA33CC;   // 0x140
      mem_arr[8'h60] <= 32'hCAFEF00D;   // 0x180
    end else begin
      if (o_mem_req && !i_mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (i_mem_ack) begin
        log_addr.push_back(o_mem_addr);
        log_wen.push_back(o_mem_wen);
        log_data.push_back(o_mem_wdata);
        if (o_mem_wen) begin
          for (int b = 0; b < 4; b++)
            if (o_mem_ben[b]) mem_arr[o_mem_addr[9:2]][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic do_reset;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
    total++; if (o_mem_wen !== 1'b0) begin bad++; $display("FAIL reset_mem_wen: got %b want 0", o_mem_wen); end
    total++; if (o_mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    total++; if (o_mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", o_mem_wdata); end
    total++; if (o_mem_ben !== 4'h0) begin bad++; $display("FAIL reset_mem_ben: got %h want 0", o_mem_ben); end
    total++; if (o_dram_data !== 32'h0) begin bad++; $display("FAIL reset_dram_data: got %h want 0", o_dram_data); end
    total++; if (o_iram_data !== 32'h0) begin bad++; $display("FAIL reset_iram_data: got %h want 0", o_iram_data); end
    total++; if (o_dram_stall !== 1'b0) begin bad++; $display("FAIL reset_dram_stall: got %b want 0", o_dram_stall); end
    total++; if (o_iram_stall !== 1'b0) begin bad++; $display("FAIL reset_iram_stall: got %b want 0", o_iram_stall); end
    @(negedge i_clk);
    i_reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_read;
    ack_en = 1'b1; ack_delay = 0;
    @(negedge i_clk);
    i_dram_rd_en = 1'b1; i_dram_addr = 32'h100;
    #1;
    total++; if (o_dram_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_first: got %b want 1", o_dram_stall); end
    @(negedge i_clk); #1;
    total++; if (o_mem_req !== 1'b1 || o_mem_wen !== 1'b0) begin bad++; $display("FAIL rd_req: got req=%b wen=%b want 1/0", o_mem_req, o_mem_wen); end
    total++; if (o_mem_addr !== 32'h100 || o_mem_ben !== 4'hF) begin bad++; $display("FAIL rd_payload: got %h/%h want 100/f", o_mem_addr, o_mem_ben); end
    total++; if (o_dram_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_ack: got %b want 0", o_dram_stall); end
    total++; if (o_dram_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", o_dram_data); end
    @(negedge i_clk);
    i_dram_rd_en = 1'b0;
    #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL rd_req_drop: got %b want 0", o_mem_req); end
    total++; if (o_dram_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold: got %h want deadbeef", o_dram_data); end
    $display("test_single_read: addr=100 data=%h", o_dram_data);
  endtask

  task automatic test_write_burst;
    int base;
    base = log_addr.size();
    ack_en = 1'b0; ack_delay = 0;
    for (int w = 0; w < 5; w++) begin
      @(negedge i_clk);
      i_dram_wr_en = 1'b1; i_dram_addr = 32'h300 + 32'(4 * w);
      i_dram_data = 32'hA000_0000 + 32'(w); i_dram_ben = 4'hF;
      #1;
      total++; if (o_dram_stall !== (w == 4)) begin bad++; $display("FAIL wr_stall_%0d: got %b want %b", w, o_dram_stall, (w == 4)); end
      $display("write %0d: addr=%h stall=%b", w, i_dram_addr, o_dram_stall);
    end
    @(negedge i_clk); #1;
    total++; if (o_dram_stall !== 1'b1) begin bad++; $display("FAIL wr_stall_full: got %b want 1", o_dram_stall); end
    total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h300) begin bad++; $display("FAIL wr_head_stable: got req=%b addr=%h want 1/300", o_mem_req, o_mem_addr); end
    @(negedge i_clk);
    ack_en = 1'b1;
    #1;
    total++; if (o_dram_stall !== 1'b0) begin bad++; $display("FAIL wr_accept_on_pop: got %b want 0", o_dram_stall); end
    @(negedge i_clk);
    i_dram_wr_en = 1'b0;
    repeat (8) @(negedge i_clk);
    total++; if (log_addr.size() - base !== 5) begin bad++; $display("FAIL wr_count: got %0d want 5", log_addr.size() - base); end
    if (log_addr.size() - base >= 5) begin
      for (int k = 0; k < 5; k++) begin
        total++; if (log_addr[base+k] !== 32'h300 + 32'(4 * k) || log_wen[base+k] !== 1'b1 || log_data[base+k] !== 32'hA000_0000 + 32'(k)) begin
          bad++; $display("FAIL wr_order_%0d: got addr=%h wen=%b data=%h want %h/1/%h", k, log_addr[base+k], log_wen[base+k], log_data[base+k], 32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_read_after_write;
    int base;
    int stalls;
    logic done;
    logic [31:0] got;
    base = log_addr.size();
    stalls = 0; done = 1'b0; got = '0;
    ack_en = 1'b1; ack_delay = 0;
    @(negedge i_clk);
    i_dram_wr_en = 1'b1; i_dram_addr = 32'h200; i_dram_data = 32'h12345678; i_dram_ben = 4'hF;
    #1;
    total++; if (o_dram_stall !== 1'b0) begin bad++; $display("FAIL raw_wr_stall: got %b want 0", o_dram_stall); end
    @(negedge i_clk);
    i_dram_wr_en = 1'b0; i_dram_rd_en = 1'b1; i_dram_addr = 32'h200;
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      if (o_dram_stall) begin
        stalls++;
        @(negedge i_clk);
      end else begin
        done = 1'b1;
        got = o_dram_data;
      end
    end
    total++; if (!done) begin bad++; $display("FAIL raw_timeout: got stall for %0d cycles want release", stalls); end
    if (done) begin
      total++; if (got !== 32'h12345678) begin bad++; $display("FAIL raw_data: got %h want 12345678", got); end
      total++; if (stalls !== 2) begin bad++; $display("FAIL raw_stalls: got %0d want 2", stalls); end
    end
    @(negedge i_clk);
    i_dram_rd_en = 1'b0;
    total++; if (log_addr.size() - base !== 2) begin bad++; $display("FAIL raw_txn_count: got %0d want 2", log_addr.size() - base); end
    if (log_addr.size() - base >= 2) begin
      total++; if (log_wen[base] !== 1'b1 || log_addr[base] !== 32'h200) begin bad++; $display("FAIL raw_first_write: got wen=%b addr=%h want 1/200", log_wen[base], log_addr[base]); end
      total++; if (log_wen[base+1] !== 1'b0 || log_addr[base+1] !== 32'h200) begin bad++; $display("FAIL raw_then_read: got wen=%b addr=%h want 0/200", log_wen[base+1], log_addr[base+1]); end
    end
    $display("test_read_after_write: data=%h stalls=%0d", got, stalls);
  endtask

  task automatic test_contention;
    logic [31:0] exp_addr;
    do_reset();
    ack_en = 1'b1; ack_delay = 0;
    @(negedge i_clk);
    i_dram_rd_en = 1'b1; i_dram_addr = 32'h100;
    i_iram_rd_en = 1'b1; i_iram_addr = 32'h180;
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clk); #1;
      exp_addr = (k % 2 == 1) ? 32'h100 : 32'h180;
      total++; if (o_mem_req !== 1'b1 || o_mem_addr !== exp_addr) begin bad++; $display("FAIL grant_%0d: got req=%b addr=%h want 1/%h", k, o_mem_req, o_mem_addr, exp_addr); end
      if (k % 2 == 1) begin
        total++; if (o_dram_stall !== 1'b0 || o_iram_stall !== 1'b1 || o_dram_data !== 32'hDEADBEEF) begin
          bad++; $display("FAIL grant_d_%0d: got dstall=%b istall=%b data=%h want 0/1/deadbeef", k, o_dram_stall, o_iram_stall, o_dram_data);
        end
      end else begin
        total++; if (o_iram_stall !== 1'b0 || o_dram_stall !== 1'b1 || o_iram_data !== 32'hCAFEF00D) begin
          bad++; $display("FAIL grant_i_%0d: got istall=%b dstall=%b data=%h want 0/1/cafef00d", k, o_iram_stall, o_dram_stall, o_iram_data);
        end
      end
      $display("contention cycle %0d: addr=%h", k, o_mem_addr);
    end
    @(negedge i_clk);
    i_dram_rd_en = 1'b0; i_iram_rd_en = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_ack_latency;
    ack_en = 1'b1; ack_delay = 3;
    @(negedge i_clk);
    i_dram_rd_en = 1'b1; i_dram_addr = 32'h140;
    #1;
    total++; if (o_dram_stall !== 1'b1) begin bad++; $display("FAIL lat_stall_0: got %b want 1", o_dram_stall); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk); #1;
      total++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h140 || o_mem_wen !== 1'b0 || o_mem_ben !== 4'hF) begin
        bad++; $display("FAIL lat_payload_%0d: got req=%b addr=%h wen=%b ben=%h want 1/140/0/f", k, o_mem_req, o_mem_addr, o_mem_wen, o_mem_ben);
      end
      total++; if (o_dram_stall !== 1'b1) begin bad++; $display("FAIL lat_stall_%0d: got %b want 1", k, o_dram_stall); end
    end
    @(negedge i_clk); #1;
    total++; if (o_dram_stall !== 1'b0 || o_dram_data !== 32'h55AA33CC) begin bad++; $display("FAIL lat_ack: got stall=%b data=%h want 0/55aa33cc", o_dram_stall, o_dram_data); end
    $display("test_ack_latency: data=%h", o_dram_data);
    @(negedge i_clk);
    i_dram_rd_en = 1'b0;
    ack_delay = 0;
    #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL lat_req_drop: got %b want 0", o_mem_req); end
  endtask

  task automatic test_reset_mid;
    int base;
    ack_en = 1'b0; ack_delay = 0;
    for (int w = 0; w < 3; w++) begin
      @(negedge i_clk);
      i_dram_wr_en = 1'b1; i_dram_addr = 32'h320 + 32'(4 * w);
      i_dram_data = 32'hB000_0000 + 32'(w); i_dram_ben = 4'hF;
    end
    @(negedge i_clk);
    i_dram_wr_en = 1'b0;
    #1;
    total++; if (o_mem_req !== 1'b1 || o_mem_wen !== 1'b1) begin bad++; $display("FAIL mid_drain_active: got req=%b wen=%b want 1/1", o_mem_req, o_mem_wen); end
    #1;
    i_reset = 1'b1;
    #1;
    total++; if (o_mem_req !== 1'b0) begin bad++; $display("FAIL mid_async_drop: got %b want 0", o_mem_req); end
    @(negedge i_clk);
    i_reset = 1'b0;
    base = log_addr.size();
    ack_en = 1'b1;
    #1;
    total++; if (o_dram_data !== 32'h0) begin bad++; $display("FAIL mid_hold_clear: got %h want 0", o_dram_data); end
    @(negedge i_clk);
    i_dram_rd_en = 1'b1; i_dram_addr = 32'h100;
    #1;
    total++; if (o_mem_req !== 1'b0 || o_dram_stall !== 1'b1) begin bad++; $display("FAIL mid_rd_wait: got req=%b stall=%b want 0/1", o_mem_req, o_dram_stall); end
    @(negedge i_clk); #1;
    total++; if (o_mem_req !== 1'b1 || o_mem_wen !== 1'b0 || o_mem_addr !== 32'h100) begin bad++; $display("FAIL mid_rd_served: got req=%b wen=%b addr=%h want 1/0/100", o_mem_req, o_mem_wen, o_mem_addr); end
    total++; if (o_dram_stall !== 1'b0 || o_dram_data !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_rd_data: got stall=%b data=%h want 0/deadbeef", o_dram_stall, o_dram_data); end
    @(negedge i_clk);
    i_dram_rd_en = 1'b0;
    repeat (2) @(negedge i_clk);
    total++; if (log_addr.size() - base !== 1) begin bad++; $display("FAIL mid_no_stale_writes: got %0d txns want 1", log_addr.size() - base); end
    $display("test_reset_mid: post-reset txns=%0d", log_addr.size() - base);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_read_after_write();
    test_contention();
    test_ack_latency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
